// File: rtl/iter_alu.sv
`default_nettype none
// ============================================================================
// iter_alu : sequential ALU, single-cycle ops plus bit-serial MUL/DIV
// Revision : 1.0
// ============================================================================
module iter_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] c_CNT_INIT = SHW'(WIDTH - 1);

    localparam logic [3:0] c_OP_ADD   = 4'd0;
    localparam logic [3:0] c_OP_SUB   = 4'd1;
    localparam logic [3:0] c_OP_AND   = 4'd2;
    localparam logic [3:0] c_OP_OR    = 4'd3;
    localparam logic [3:0] c_OP_XOR   = 4'd4;
    localparam logic [3:0] c_OP_SLT   = 4'd5;
    localparam logic [3:0] c_OP_SLTU  = 4'd6;
    localparam logic [3:0] c_OP_SLL   = 4'd7;
    localparam logic [3:0] c_OP_SRL   = 4'd8;
    localparam logic [3:0] c_OP_SRA   = 4'd9;
    localparam logic [3:0] c_OP_MUL   = 4'd10;
    localparam logic [3:0] c_OP_MULHU = 4'd11;
    localparam logic [3:0] c_OP_DIVU  = 4'd12;
    localparam logic [3:0] c_OP_REMU  = 4'd13;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SHW-1:0]     r_cnt;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_opnd;
    logic [2*WIDTH-1:0] r_acc;

    logic               w_accept;
    logic               w_iter_op;
    logic               w_op_mul;
    logic               w_op_div;
    logic [WIDTH-1:0]   w_b_eff;
    logic               w_cin;
    logic [WIDTH:0]     w_sum_ext;
    logic [SHW-1:0]     w_shamt;
    logic [WIDTH-1:0]   w_sc_res;
    logic               w_sc_c;
    logic               w_sc_v;

    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_nxt;
    logic [WIDTH:0]     w_div_sh;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_diff;
    logic [2*WIDTH-1:0] w_div_nxt;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0]   w_it_res;

    assign w_accept  = start && (r_state != S_CALC);
    assign w_op_mul  = (op_in == c_OP_MUL) || (op_in == c_OP_MULHU);
    assign w_op_div  = (op_in == c_OP_DIVU) || (op_in == c_OP_REMU);
    assign w_iter_op = w_op_mul || w_op_div;

    assign busy = (r_state == S_CALC);
    assign done = (r_state == S_DONE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_state_nxt = w_iter_op ? S_CALC : S_DONE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CALC: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Single-cycle datapath: SUB reuses the adder as a + ~b + 1
    assign w_cin     = (op_in == c_OP_SUB);
    assign w_b_eff   = w_cin ? ~b_in : b_in;
    assign w_sum_ext = {1'b0, a_in} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin};
    assign w_shamt   = b_in[SHW-1:0];

    always_comb begin
        w_sc_res = '0;
        w_sc_c   = 1'b0;
        w_sc_v   = 1'b0;
        case (op_in)
            c_OP_ADD, c_OP_SUB: begin
                w_sc_res = w_sum_ext[WIDTH-1:0];
                w_sc_c   = w_sum_ext[WIDTH];
                w_sc_v   = (a_in[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                           (w_sum_ext[WIDTH-1] != a_in[WIDTH-1]);
            end
            c_OP_AND:  w_sc_res = a_in & b_in;
            c_OP_OR:   w_sc_res = a_in | b_in;
            c_OP_XOR:  w_sc_res = a_in ^ b_in;
            c_OP_SLT:  w_sc_res = {{(WIDTH-1){1'b0}}, ($signed(a_in) < $signed(b_in))};
            c_OP_SLTU: w_sc_res = {{(WIDTH-1){1'b0}}, (a_in < b_in)};
            c_OP_SLL:  w_sc_res = a_in << w_shamt;
            c_OP_SRL:  w_sc_res = a_in >> w_shamt;
            c_OP_SRA:  w_sc_res = $unsigned($signed(a_in) >>> w_shamt);
            default:   w_sc_res = '0;
        endcase
    end

    // r_acc holds {hi, lo}: product for multiply, {remainder, quotient} for divide
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                        (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    assign w_mul_nxt  = {w_mul_sum, r_acc[WIDTH-1:1]};
    assign w_div_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_ge   = (w_div_sh >= {1'b0, r_opnd});
    assign w_div_diff = w_div_sh[WIDTH-1:0] - r_opnd;
    assign w_div_nxt  = {(w_div_ge ? w_div_diff : w_div_sh[WIDTH-1:0]),
                         r_acc[WIDTH-2:0], w_div_ge};
    assign w_acc_nxt  = ((r_op == c_OP_DIVU) || (r_op == c_OP_REMU)) ? w_div_nxt : w_mul_nxt;

    always_comb begin
        w_it_res = w_acc_nxt[WIDTH-1:0];
        case (r_op)
            c_OP_MULHU, c_OP_REMU: w_it_res = w_acc_nxt[2*WIDTH-1:WIDTH];
            default:               w_it_res = w_acc_nxt[WIDTH-1:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_opnd  <= '0;
            r_acc   <= '0;
            result  <= '0;
            Z       <= 1'b0;
            N       <= 1'b0;
            C       <= 1'b0;
            V       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op   <= op_in;
                r_opnd <= w_op_mul ? a_in : b_in;
                r_acc  <= {{WIDTH{1'b0}}, (w_op_div ? a_in : b_in)};
                if (w_iter_op) begin
                    r_cnt <= c_CNT_INIT;
                end else begin
                    result <= w_sc_res;
                    Z      <= (w_sc_res == '0);
                    N      <= w_sc_res[WIDTH-1];
                    C      <= w_sc_c;
                    V      <= w_sc_v;
                end
            end else if (r_state == S_CALC) begin
                r_acc <= w_acc_nxt;
                if (r_cnt == '0) begin
                    result <= w_it_res;
                    Z      <= (w_it_res == '0);
                    N      <= w_it_res[WIDTH-1];
                    C      <= 1'b0;
                    V      <= 1'b0;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iter_alu.sv
`default_nettype none
// ============================================================================
// tb_iter_alu : directed self-checking bench for iter_alu (WIDTH = 32)
// Revision    : 1.0
// ============================================================================
module tb_iter_alu;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        Z;
    logic        N;
    logic        C;
    logic        V;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;
    int bcnt;

    iter_alu #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op_in  (op),
        .a_in   (a),
        .b_in   (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .Z      (Z),
        .N      (N),
        .C      (C),
        .V      (V)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one start pulse; returns at the falling edge after the accepting edge.
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts falling edges until done (bounded), and busy cycles seen on the way.
    task automatic wait_done(output int l, output int bc);
        l  = 0;
        bc = busy ? 1 : 0;
        while (!done && l < 40) begin
            @(negedge clk);
            l++;
            if (busy) bc++;
        end
    endtask

    function automatic logic [31:0] flags();
        return {28'd0, Z, N, C, V};
    endfunction

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = 4'd0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk("reset_result", result, 32'h0);
        chk("reset_ctl", {30'd0, busy, done}, 32'h0);
        chk("reset_flags", flags(), 32'h0);
        rst_n = 1'b1;

        // ADD overflow to zero
        issue(4'd0, 32'hFFFF_FFFF, 32'h1);
        chk("add_done", {30'd0, busy, done}, 32'h1);
        chk("add_res", result, 32'h0);
        chk("add_flags", flags(), 32'hA);
        @(negedge clk);
        chk("add_done_once", {31'd0, done}, 32'h0);

        issue(4'd1, 32'h8000_0000, 32'h1);
        chk("sub_res", result, 32'h7FFF_FFFF);
        chk("sub_flags", flags(), 32'h3);

        issue(4'd5, 32'hFFFF_FFFF, 32'h1);
        chk("slt_res", result, 32'h1);
        issue(4'd6, 32'hFFFF_FFFF, 32'h1);
        chk("sltu_res", result, 32'h0);
        chk("sltu_flags", flags(), 32'h8);

        issue(4'd9, 32'h8000_0000, 32'd36);
        chk("sra_res", result, 32'hF800_0000);
        chk("sra_flags", flags(), 32'h4);
        issue(4'd8, 32'h8000_0000, 32'd36);
        chk("srl_res", result, 32'h0800_0000);
        issue(4'd7, 32'h1, 32'd31);
        chk("sll_res", result, 32'h8000_0000);
        chk("sll_flags", flags(), 32'h4);
        issue(4'd4, 32'h0000_F0F0, 32'h0000_FF00);
        chk("xor_res", result, 32'h0000_0FF0);
        issue(4'd2, 32'h0000_F0F0, 32'h0000_FF00);
        chk("and_res", result, 32'h0000_F000);
        issue(4'd3, 32'h0000_F0F0, 32'h0000_FF00);
        chk("or_res", result, 32'h0000_FFF0);
        issue(4'd15, 32'h1234_5678, 32'h1);
        chk("op15_res", result, 32'h0);
        chk("op15_flags", flags(), 32'h8);

        // MUL: latency and busy window
        issue(4'd10, 32'h0001_0000, 32'h0001_0000);
        wait_done(lat, bcnt);
        chk("mul_latency", lat, 32);
        chk("mul_busy_cycles", bcnt, 32);
        chk("mul_res", result, 32'h0);
        chk("mul_flags", flags(), 32'h8);

        // MULHU with an ADD start pulsed mid-operation that must be ignored
        issue(4'd11, 32'h0001_0000, 32'h0001_0000);
        repeat (5) @(negedge clk);
        start = 1'b1;
        op    = 4'd0;
        a     = 32'h1;
        b     = 32'h1;
        @(negedge clk);
        start = 1'b0;
        chk("mulhu_still_busy", {30'd0, busy, done}, 32'h2);
        wait_done(lat, bcnt);
        chk("mulhu_latency_rest", lat, 26);
        chk("mulhu_res", result, 32'h1);
        chk("mulhu_flags", flags(), 32'h0);
        @(negedge clk);
        chk("mulhu_no_extra_done", {30'd0, busy, done}, 32'h0);
        chk("mulhu_res_hold", result, 32'h1);

        // DIVU then back-to-back REMU issued in the DONE cycle
        issue(4'd12, 32'd100, 32'd7);
        wait_done(lat, bcnt);
        chk("divu_latency", lat, 32);
        chk("divu_res", result, 32'd14);
        start = 1'b1;
        op    = 4'd13;
        a     = 32'd100;
        b     = 32'd7;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_accepted", {30'd0, busy, done}, 32'h2);
        wait_done(lat, bcnt);
        chk("remu_latency", lat, 32);
        chk("remu_res", result, 32'd2);

        issue(4'd12, 32'd5, 32'd0);
        wait_done(lat, bcnt);
        chk("divu0_latency", lat, 32);
        chk("divu0_res", result, 32'hFFFF_FFFF);
        chk("divu0_flags", flags(), 32'h4);
        issue(4'd13, 32'd5, 32'd0);
        wait_done(lat, bcnt);
        chk("remu0_res", result, 32'd5);

        // Reset mid-divide
        issue(4'd12, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_ctl", {30'd0, busy, done}, 32'h0);
        chk("rst_mid_res", result, 32'h0);
        chk("rst_mid_flags", flags(), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_no_done", {30'd0, busy, done}, 32'h0);
        issue(4'd0, 32'd2, 32'd3);
        chk("post_rst_done", {30'd0, busy, done}, 32'h1);
        chk("post_rst_res", result, 32'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
